firebird7_in_gate1_tessent_data_mux_mc: RTL

FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_MC -- requirements
Module: firebird7_in_gate1_tessent_data_mux_mc

---
 rtl/firebird7_in_gate1_tessent_data_mux_mc.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_mc.sv
// Per-channel functional/IJTAG data mux with a settle hold on every source switch.
// Optional registered even parity per channel when TESSENT_DATA_MUX_PARITY_EN is defined.
module firebird7_in_gate1_tessent_data_mux_mc #(
  parameter int unsigned WIDTH  = 19,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic [NUM_CH-1:0]       ijtag_select,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       ijtag_active,
`ifdef TESSENT_DATA_MUX_PARITY_EN
  output logic [NUM_CH-1:0]       switch_busy,
  output logic [NUM_CH-1:0]       data_out_parity
`else
  output logic [NUM_CH-1:0]       switch_busy
`endif
);

  typedef enum logic [1:0] {
    StFunc  = 2'd0,
    StHoldI = 2'd1,
    StIjtag = 2'd2,
    StHoldF = 2'd3
  } state_e;

  // Hold count is loaded with SETTLE-1 so the output is frozen for exactly SETTLE edges.
  localparam int unsigned HoldInitInt = (SETTLE > 0) ? (SETTLE - 1) : 0;
  localparam logic [3:0]  HoldInit    = 4'(HoldInitInt);

  state_e                    r_state [NUM_CH];
  logic   [3:0]              r_cnt   [NUM_CH];
  logic   [NUM_CH*WIDTH-1:0] r_data;

  state_e                    w_state_d [NUM_CH];
  logic   [3:0]              w_cnt_d   [NUM_CH];
  logic   [NUM_CH-1:0]       w_load_f;
  logic   [NUM_CH-1:0]       w_load_i;
  logic   [NUM_CH*WIDTH-1:0] w_data_d;

  always_comb begin
    w_load_f = '0;
    w_load_i = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_state_d[c] = r_state[c];
      w_cnt_d[c]   = r_cnt[c];
      unique case (r_state[c])
        StFunc: begin
          if (ijtag_select[c]) begin
            if (SETTLE == 0) begin
              w_state_d[c] = StIjtag;
              w_load_i[c]  = 1'b1;
            end else begin
              w_state_d[c] = StHoldI;
              w_cnt_d[c]   = HoldInit;
            end
          end else begin
            w_load_f[c] = 1'b1;
          end
        end
        StHoldI: begin
          // Abort wins over expiry.
          if (!ijtag_select[c]) begin
            w_state_d[c] = StFunc;
            w_cnt_d[c]   = '0;
            w_load_f[c]  = 1'b1;
          end else if (r_cnt[c] == 4'd0) begin
            w_state_d[c] = StIjtag;
            w_load_i[c]  = 1'b1;
          end else begin
            w_cnt_d[c] = r_cnt[c] - 4'd1;
          end
        end
        StIjtag: begin
          if (!ijtag_select[c]) begin
            if (SETTLE == 0) begin
              w_state_d[c] = StFunc;
              w_load_f[c]  = 1'b1;
            end else begin
              w_state_d[c] = StHoldF;
              w_cnt_d[c]   = HoldInit;
            end
          end else begin
            w_load_i[c] = 1'b1;
          end
        end
        StHoldF: begin
          if (ijtag_select[c]) begin
            w_state_d[c] = StIjtag;
            w_cnt_d[c]   = '0;
            w_load_i[c]  = 1'b1;
          end else if (r_cnt[c] == 4'd0) begin
            w_state_d[c] = StFunc;
            w_load_f[c]  = 1'b1;
          end else begin
            w_cnt_d[c] = r_cnt[c] - 4'd1;
          end
        end
        default: begin
          w_state_d[c] = StFunc;
          w_cnt_d[c]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_data_d = r_data;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_load_i[c]) begin
        w_data_d[c*WIDTH +: WIDTH] = ijtag_data_in[c*WIDTH +: WIDTH];
      end else if (w_load_f[c]) begin
        w_data_d[c*WIDTH +: WIDTH] = functional_data_in[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_state[c] <= StFunc;
        r_cnt[c]   <= '0;
      end
      r_data <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_state[c] <= w_state_d[c];
        r_cnt[c]   <= w_cnt_d[c];
      end
      r_data <= w_data_d;
    end
  end

  assign data_out = r_data;

  always_comb begin
    ijtag_active = '0;
    switch_busy  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ijtag_active[c] = (r_state[c] == StIjtag);
      switch_busy[c]  = (r_state[c] == StHoldI) || (r_state[c] == StHoldF);
    end
  end

`ifdef TESSENT_DATA_MUX_PARITY_EN
  logic [NUM_CH-1:0] r_parity;
  logic [NUM_CH-1:0] w_parity_d;

  // Parity of the next data value keeps it aligned with data_out on the same edge.
  always_comb begin
    w_parity_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_parity_d[c] = ^w_data_d[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_parity <= '0;
    end else begin
      r_parity <= w_parity_d;
    end
  end

  assign data_out_parity = r_parity;
`endif

endmodule
